wide_add_seq: RTL

Multi-cycle wide-operand adder/subtractor that reuses one `cla16` instance across `WORDS` consecutive 16-bit slices, least-significant slice first. The carry is chained through a register between slices. The block sits between an issuing unit and a result consumer, with a valid/ready handshake on each side. It trades latency for area when operands wider than 16 bits are required.

---
 rtl/cla16.sv | 50 +++++
 rtl/wide_add_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// and a lookahead carry across the groups. There is no carry-out port.
module cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [15:0] w_g;
  logic [15:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    logic [3:0] w_gg;
    logic [3:0] w_gp;
    logic [4:0] w_gc;
    logic       w_c;
    w_gg  = '0;
    w_gp  = '0;
    w_gc  = '0;
    w_c   = 1'b0;
    o_sum = '0;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = 1'b0;
      w_gp[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        w_gg[j] = w_g[4*j+i] | (w_p[4*j+i] & w_gg[j]);
        w_gp[j] = w_gp[j] & w_p[4*j+i];
      end
    end
    // Group carries are expanded two-level so they do not ripple group to group.
    w_gc[0] = i_cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gc[3]);
    for (int j = 0; j < 4; j++) begin
      w_c = w_gc[j];
      for (int i = 0; i < 4; i++) begin
        o_sum[4*j+i] = w_p[4*j+i] ^ w_c;
        w_c          = w_g[4*j+i] | (w_p[4*j+i] & w_c);
      end
    end
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder/subtractor: one cla16 walks WORDS 16-bit slices,
// LSB slice first, with the carry held in a register between slices.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic [1:0]            o_dbg_state
);

  localparam int         W      = 16 * WORDS;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [3:0] K_LAST = 4'(WORDS - 1);

  logic [1:0]   r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_sum;
  logic         r_c;
  logic [3:0]   r_k;
  logic         r_cout;
  logic         r_ovf;

  logic [15:0]  w_s;
  logic [W-1:0] w_sum_next;
  logic         w_a15;
  logic         w_b15;
  logic         w_s15;
  logic         w_c_next;
  logic         w_ovf;

  cla16 u_cla16 (
    .i_a   (r_a[15:0]),
    .i_b   (r_b[15:0]),
    .i_cin (r_c),
    .o_sum (w_s)
  );

  assign w_a15    = r_a[15];
  assign w_b15    = r_b[15];
  assign w_s15    = w_s[15];
  // Carry out of the slice recovered from its top bits, since cla16 hides it.
  assign w_c_next = (w_a15 & w_b15) | ((w_a15 ^ w_b15) & ~w_s15);
  assign w_ovf    = (w_a15 == w_b15) & (w_s15 != w_a15);

  generate
    if (WORDS == 1) begin : g_one
      assign w_sum_next = w_s;
    end else begin : g_many
      assign w_sum_next = {w_s, r_sum[W-1:16]};
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid come only from state bits, gated low during reset.
  assign in_ready    = rst_n & (r_state == S_IDLE);
  assign out_valid   = rst_n & (r_state == S_DONE);
  assign out_sum     = r_sum;
  assign out_cout    = r_cout;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_c     <= in_sub;
            r_k     <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_a   <= r_a >> 16;
          r_b   <= r_b >> 16;
          r_sum <= w_sum_next;
          r_c   <= w_c_next;
          r_k   <= r_k + 4'd1;
          if (r_k == K_LAST) begin
            r_cout  <= w_c_next;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
